// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, instruction field positions and default widths for the fetch stage.
package fetch_unit_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_INSTR_W = 16;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int TGT_MSB = 10;
  localparam int TGT_LSB = 1;
  localparam logic [4:0] OPCODE_NOP = 5'h00;
  localparam logic [4:0] OPCODE_MVL = 5'h01;
  localparam logic [4:0] OPCODE_ADD = 5'h02;
  localparam logic [4:0] OPCODE_SUB = 5'h03;
  localparam logic [4:0] OPCODE_LD  = 5'h04;
  localparam logic [4:0] OPCODE_ST  = 5'h05;
  localparam logic [4:0] OPCODE_BEQ = 5'h06;
  localparam logic [4:0] OPCODE_JMP = 5'h1E;
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_pkt_t;
  function automatic logic is_jmp(input logic [DEF_INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB] == OPCODE_JMP;
  endfunction
  function automatic logic [DEF_ADDR_W-1:0] jmp_target(input logic [DEF_INSTR_W-1:0] w);
    return w[TGT_MSB:TGT_LSB];
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM port, decode handshake and execute redirect of the fetch stage.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  modport master (
    output rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid,
    output rom_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven ROM fetch with registered valid/ready output and execute redirects.
// Define FETCH_JMP_FOLD_EN to consume JMP words in fetch (static jump folding).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);
  logic [ADDR_W-1:0]  pc_q, pc_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               advance, fold, load;
`ifdef FETCH_JMP_FOLD_EN
  assign fold = advance && !bus.redirect_valid && is_jmp(bus.rom_data);
`else
  assign fold = 1'b0;
`endif
  always_comb begin
    advance = !valid_q || bus.instr_ready;
    load    = advance && !bus.redirect_valid && !fold;
    pc_d    = bus.redirect_valid ? bus.redirect_pc :
              fold               ? ADDR_W'(jmp_target(bus.rom_data)) :
              advance            ? pc_q + ADDR_W'(1) : pc_q;
    valid_d = (bus.redirect_valid || fold) ? 1'b0 : advance ? 1'b1 : valid_q;
    instr_d = load ? bus.rom_data : instr_q;
    ipc_d   = load ? pc_q : ipc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, async-reset sequences and a randomized stream scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] rom [1024];
  assign bus.rom_data = rom[bus.rom_addr];
  int errors = 0;
  int checks = 0;
  int xfers = 0;
  typedef struct {
    logic       rdy;
    logic       rv;
    logic [9:0] rpc;
    logic       ev;
    logic [9:0] epc;
    logic [9:0] eaddr;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rdy, input logic rv, input logic [9:0] rpc);
    bus.instr_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
  endtask
  task automatic add(input logic rdy, rv, input logic [9:0] rpc, input logic ev, input logic [9:0] epc, eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    tv.push_back(v);
  endtask
  function automatic logic [9:0] resolve(input logic [9:0] a);
    logic [9:0] r;
    r = a;
`ifdef FETCH_JMP_FOLD_EN
    for (int i = 0; i < 8; i++)
      if (rom[r][15:11] == OPCODE_JMP) r = rom[r][10:1];
`endif
    return r;
  endfunction
  initial begin
    logic       rdy, rv, pv;
    logic [9:0] rpc, pp, exp_pc, nx;
    logic [15:0] pi;
    for (int a = 0; a < 1024; a++) rom[a] = {OPCODE_ADD, 10'(a), 1'b1};
    rom[0]  = 16'h0937;
    rom[10] = {OPCODE_JMP, 10'h00A, 1'b0};
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 10'(i), 10'(i + 1));
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 10'h003, 10'h004);
    add(1, 0, 0, 1, 10'h004, 10'h005);
    add(1, 0, 0, 1, 10'h005, 10'h006);
    add(1, 1, 10'h005, 0, 0, 10'h005);
    add(1, 0, 0, 1, 10'h005, 10'h006);
    add(1, 1, 10'h3FF, 0, 0, 10'h3FF);
    add(1, 0, 0, 1, 10'h3FF, 10'h000);
    add(1, 0, 0, 1, 10'h000, 10'h001);
    add(1, 1, 10'h008, 0, 0, 10'h008);
    add(1, 0, 0, 1, 10'h008, 10'h009);
    add(1, 0, 0, 1, 10'h009, 10'h00A);
`ifdef FETCH_JMP_FOLD_EN
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 10'h00A);
`else
    add(1, 0, 0, 1, 10'h00A, 10'h00B);
    add(1, 0, 0, 1, 10'h00B, 10'h00C);
`endif
    drive(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tv[k]) begin
      drive(tv[k].rdy, tv[k].rv, tv[k].rpc);
      @(posedge clk); #1;
      chk($sformatf("tv%0d_valid", k), bus.instr_valid, tv[k].ev);
      chk($sformatf("tv%0d_addr", k), bus.rom_addr, tv[k].eaddr);
      if (tv[k].ev) begin
        chk($sformatf("tv%0d_ipc", k), bus.instr_pc, tv[k].epc);
        chk($sformatf("tv%0d_instr", k), bus.instr, rom[tv[k].epc]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0);
    @(posedge clk); #1;
    chk("first_ipc", bus.instr_pc, 0);
    chk("first_instr", bus.instr, 16'h0937);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", bus.instr_valid, 0);
    chk("async_addr", bus.rom_addr, 0);
    chk("async_instr", bus.instr, 0);
    drive(1, 1, 10'h123);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_redir_valid", bus.instr_valid, 0);
    chk("rel_redir_addr", bus.rom_addr, 10'h123);
    drive(1, 0, 0);
    @(posedge clk); #1;
    chk("rel_redir_ipc", bus.instr_pc, 10'h123);
    for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 10'h000;
    for (int n = 0; n < 3000; n++) begin
      rdy = $urandom_range(0, 3) != 0;
      rv  = $urandom_range(0, 15) == 0;
      rpc = 10'($urandom);
      drive(rdy, rv, rpc);
      pv = bus.instr_valid; pi = bus.instr; pp = bus.instr_pc;
      @(posedge clk); #1;
      if (rv) begin
        chk("rnd_redir_valid", bus.instr_valid, 0);
        chk("rnd_redir_addr", bus.rom_addr, rpc);
        exp_pc = rpc;
      end else if (pv && !rdy) begin
        chk("rnd_stall_valid", bus.instr_valid, 1);
        chk("rnd_stall_ipc", bus.instr_pc, pp);
        chk("rnd_stall_instr", bus.instr, pi);
      end else if (bus.instr_valid) begin
        nx = bus.instr_pc + 10'd1;
        chk("rnd_ipc", bus.instr_pc, resolve(exp_pc));
        chk("rnd_instr", bus.instr, rom[bus.instr_pc]);
        chk("rnd_addr", bus.rom_addr, nx);
        exp_pc = nx;
        xfers++;
      end else begin
`ifndef FETCH_JMP_FOLD_EN
        chk("rnd_adv_valid", bus.instr_valid, 1);
`endif
      end
    end
    chk("rnd_live", 32'(xfers > 200), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
